// File: rtl/control_cmd_dispatch_pkg.sv
// Shared constants and types for the UART command dispatcher.
// Opcode table index doubles as the handler index.
package control_cmd_dispatch_pkg;

  localparam int NUM_CMDS = 4;
  localparam int CMD_IDX_W = $clog2(NUM_CMDS);
  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

  localparam logic [7:0] CMD_NOP = 8'h00;
  localparam logic [NUM_CMDS-1:0][7:0] CMD_OPCODES = {
    8'h42, 8'h46, 8'h4C, 8'h52
  };

  typedef logic [CMD_IDX_W-1:0] cmd_index_t;
  typedef logic [NUM_CMDS-1:0] cmd_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    ABORT
  } dispatch_state_t;

endpackage

// File: rtl/control_cmd_dispatch_if.sv
// Byte-in / handler-out bundle of the command dispatcher.
// master = dispatcher side, slave = receiver + handlers side.
interface control_cmd_dispatch_if;
  import control_cmd_dispatch_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] cmd_data;
  cmd_vec_t   cmd_enable;
  cmd_vec_t   cmd_done;
  cmd_vec_t   cmd_reset;
  cmd_index_t active_cmd;
  logic       busy;
  logic       err_unknown;
  logic       err_timeout;

  modport master (
    input  rx_data, rx_valid, cmd_done,
    output cmd_data, cmd_enable, cmd_reset,
    output active_cmd, busy,
    output err_unknown, err_timeout
  );

  modport slave (
    output rx_data, rx_valid, cmd_done,
    input  cmd_data, cmd_enable, cmd_reset,
    input  active_cmd, busy,
    input  err_unknown, err_timeout
  );

endinterface

// File: rtl/control_cmd_timeout.sv
// Loadable saturating up-counter with clear and terminal-count flag.
// Clear beats load, load beats count; it parks at MAX_COUNT.
module control_cmd_timeout #(
  parameter int MAX_COUNT = 65535,
  parameter int TERMINAL  = MAX_COUNT - 1,
  parameter int W         = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         terminal
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && count_q != W'(MAX_COUNT)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign terminal = (count_q == W'(TERMINAL));

endmodule

// File: rtl/control_cmd_dispatch.sv
// Routes UART bytes: first byte picks a handler, the rest are strobed
// to it until it reports done or the host stalls past the timeout.
module control_cmd_dispatch
  import control_cmd_dispatch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  control_cmd_dispatch_if.master bus
);

  dispatch_state_t state_q, state_n;
  cmd_index_t      active_q, active_n;
  logic [7:0]      data_q, data_n;
  cmd_vec_t        enable_q, enable_n;
  cmd_vec_t        creset_q, creset_n;
  logic            eunk_q, eunk_n;
  logic            etmo_q, etmo_n;

  logic            tmo_clear, tmo_inc, tmo_term;
  logic            dec_hit, dec_unknown, take_op;
  cmd_index_t      dec_idx;

  control_cmd_timeout #(
    .MAX_COUNT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear     (tmo_clear),
    .load      (1'b0),
    .load_value('0),
    .enable    (tmo_inc),
    .terminal  (tmo_term)
  );

  // Lowest index wins if the table ever holds duplicates.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (!dec_hit && bus.rx_data == CMD_OPCODES[i]) begin
        dec_hit = 1'b1;
        dec_idx = cmd_index_t'(i);
      end
    end
    dec_unknown = !dec_hit && (bus.rx_data != CMD_NOP);
  end

  always_comb begin
    state_n   = state_q;
    active_n  = active_q;
    data_n    = data_q;
    enable_n  = '0;
    creset_n  = '0;
    eunk_n    = 1'b0;
    etmo_n    = 1'b0;
    tmo_clear = 1'b0;
    tmo_inc   = 1'b0;
    take_op   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmo_clear = 1'b1;
        take_op   = bus.rx_valid;
      end
      ROUTE: begin
        if (bus.cmd_done[active_q]) begin
          state_n   = IDLE;
          tmo_clear = 1'b1;
          take_op   = bus.rx_valid;
        end else if (bus.rx_valid) begin
          data_n             = bus.rx_data;
          enable_n[active_q] = 1'b1;
          tmo_clear          = 1'b1;
        end else if (tmo_term) begin
          state_n            = ABORT;
          creset_n[active_q] = 1'b1;
          etmo_n             = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ABORT: begin
        state_n   = IDLE;
        tmo_clear = 1'b1;
      end
      default: begin
        state_n   = IDLE;
        tmo_clear = 1'b1;
      end
    endcase

    if (take_op) begin
      if (dec_hit) begin
        state_n   = ROUTE;
        active_n  = dec_idx;
        tmo_clear = 1'b1;
      end
      eunk_n = dec_unknown;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      active_q <= '0;
      data_q   <= '0;
      enable_q <= '0;
      creset_q <= '0;
      eunk_q   <= 1'b0;
      etmo_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      active_q <= active_n;
      data_q   <= data_n;
      enable_q <= enable_n;
      creset_q <= creset_n;
      eunk_q   <= eunk_n;
      etmo_q   <= etmo_n;
    end
  end

  assign bus.cmd_data    = data_q;
  assign bus.cmd_enable  = enable_q;
  assign bus.cmd_reset   = creset_q;
  assign bus.active_cmd  = active_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err_unknown = eunk_q;
  assign bus.err_timeout = etmo_q;

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Directed scenarios plus randomized traffic against a transaction-level
// model of the dispatcher (opcode table, silence counter, abort flag).
module tb_control_cmd_dispatch;
  import control_cmd_dispatch_pkg::*;

  localparam int T = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  control_cmd_dispatch_if bus ();

  control_cmd_dispatch #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] op_tab [4];

  bit         m_route;
  bit         m_abort;
  int         m_h;
  int         m_silent;
  logic [3:0] e_enable;
  logic [3:0] e_creset;
  logic [7:0] e_data;
  bit         e_eunk;
  bit         e_etmo;

  function automatic int opcode_index(input logic [7:0] d);
    for (int i = 0; i < 4; i++) begin
      if (op_tab[i] == d) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input bit rst, input bit v,
                            input logic [7:0] d,
                            input logic [3:0] done);
    bit take;
    int idx;
    take     = 1'b0;
    e_enable = '0;
    e_creset = '0;
    e_eunk   = 1'b0;
    e_etmo   = 1'b0;
    if (rst) begin
      m_route  = 1'b0;
      m_abort  = 1'b0;
      m_h      = 0;
      m_silent = 0;
      e_data   = '0;
      return;
    end
    if (m_abort) begin
      m_abort = 1'b0;
      m_route = 1'b0;
    end else if (!m_route) begin
      take = v;
    end else if (done[m_h]) begin
      m_route = 1'b0;
      take    = v;
    end else if (v) begin
      e_enable[m_h] = 1'b1;
      e_data        = d;
      m_silent      = 0;
    end else begin
      m_silent++;
      if (m_silent == T) begin
        e_creset[m_h] = 1'b1;
        e_etmo        = 1'b1;
        m_abort       = 1'b1;
      end
    end
    if (take) begin
      idx = opcode_index(d);
      if (idx >= 0) begin
        m_route  = 1'b1;
        m_h      = idx;
        m_silent = 0;
      end else if (d != 8'h00) begin
        e_eunk = 1'b1;
      end
    end
  endtask

  task automatic tick(input bit rst, input bit v,
                      input logic [7:0] d,
                      input logic [3:0] done);
    @(negedge clk);
    reset        = rst;
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.cmd_done = done;
    @(posedge clk);
    model_step(rst, v, d, done);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 8'h52, 4'hF);
    tick(1'b1, 1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_enable !== 4'h0) begin
      errors++;
      $display("FAIL reset_busy_en: got busy=%b en=%b required 0/0000",
               bus.busy, bus.cmd_enable);
    end
    checks++;
    if (bus.cmd_reset !== 4'h0 || bus.err_unknown !== 1'b0 ||
        bus.err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_errs: got crst=%b eu=%b et=%b required 0",
               bus.cmd_reset, bus.err_unknown, bus.err_timeout);
    end
    checks++;
    if (bus.cmd_data !== 8'h00 || bus.active_cmd !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: got data=%h act=%0d required 00/0",
               bus.cmd_data, bus.active_cmd);
    end
    tick(1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  task automatic test_route_basic();
    logic [7:0] pl [4];
    pl[0] = 8'h05; pl[1] = 8'h10; pl[2] = 8'hAB; pl[3] = 8'hCD;
    tick(1'b0, 1'b1, 8'h52, 4'h0);
    checks++;
    if (bus.busy !== 1'b1 || bus.active_cmd !== 2'd0 ||
        bus.cmd_enable !== 4'h0) begin
      errors++;
      $display("FAIL route_open: got busy=%b act=%0d en=%b required 1/0/0000",
               bus.busy, bus.active_cmd, bus.cmd_enable);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, pl[i], 4'h0);
      checks++;
      if (bus.cmd_enable !== 4'b0001 || bus.cmd_data !== pl[i]) begin
        errors++;
        $display("FAIL route_byte%0d: got en=%b data=%h required 0001/%h",
                 i, bus.cmd_enable, bus.cmd_data, pl[i]);
      end
      tick(1'b0, 1'b0, 8'h00, 4'h0);
      checks++;
      if (bus.cmd_enable !== 4'h0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL route_gap%0d: got en=%b busy=%b required 0000/1",
                 i, bus.cmd_enable, bus.busy);
      end
    end
    tick(1'b0, 1'b0, 8'h00, 4'b0001);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL route_done: got busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_unknown_nop();
    tick(1'b0, 1'b1, 8'h7E, 4'h0);
    checks++;
    if (bus.err_unknown !== 1'b1 || bus.busy !== 1'b0 ||
        bus.cmd_enable !== 4'h0) begin
      errors++;
      $display("FAIL unknown: got eu=%b busy=%b en=%b required 1/0/0000",
               bus.err_unknown, bus.busy, bus.cmd_enable);
    end
    tick(1'b0, 1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.err_unknown !== 1'b0) begin
      errors++;
      $display("FAIL unknown_pulse: got eu=%b required 0", bus.err_unknown);
    end
    tick(1'b0, 1'b1, 8'h00, 4'h0);
    checks++;
    if (bus.err_unknown !== 1'b0 || bus.busy !== 1'b0 ||
        bus.cmd_enable !== 4'h0) begin
      errors++;
      $display("FAIL nop: got eu=%b busy=%b en=%b required 0/0/0000",
               bus.err_unknown, bus.busy, bus.cmd_enable);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    tick(1'b0, 1'b1, 8'h46, 4'h0);
    tick(1'b0, 1'b1, 8'h99, 4'h0);
    checks++;
    if (bus.cmd_enable !== 4'b0100 || bus.cmd_data !== 8'h99) begin
      errors++;
      $display("FAIL tmo_byte: got en=%b data=%h required 0100/99",
               bus.cmd_enable, bus.cmd_data);
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3 * T) begin
      tick(1'b0, 1'b0, 8'h00, 4'h0);
      n++;
      if (bus.err_timeout === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != T) begin
      errors++;
      $display("FAIL tmo_delay: got seen=%b after %0d cycles required %0d",
               seen, n, T);
    end
    checks++;
    if (bus.cmd_reset !== 4'b0100 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_reset: got crst=%b busy=%b required 0100/1",
               bus.cmd_reset, bus.busy);
    end
    tick(1'b0, 1'b1, 8'h33, 4'h0);
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_enable !== 4'h0 ||
        bus.err_timeout !== 1'b0 || bus.cmd_reset !== 4'h0) begin
      errors++;
      $display("FAIL tmo_after: got busy=%b en=%b et=%b crst=%b required 0",
               bus.busy, bus.cmd_enable, bus.err_timeout, bus.cmd_reset);
    end
    tick(1'b0, 1'b1, 8'h52, 4'h0);
    checks++;
    if (bus.busy !== 1'b1 || bus.active_cmd !== 2'd0) begin
      errors++;
      $display("FAIL tmo_reroute: got busy=%b act=%0d required 1/0",
               bus.busy, bus.active_cmd);
    end
  endtask

  task automatic test_done_opcode();
    tick(1'b0, 1'b1, 8'h11, 4'h0);
    tick(1'b0, 1'b1, 8'h42, 4'b0001);
    checks++;
    if (bus.busy !== 1'b1 || bus.active_cmd !== 2'd3 ||
        bus.cmd_enable !== 4'h0) begin
      errors++;
      $display("FAIL done_op: got busy=%b act=%0d en=%b required 1/3/0000",
               bus.busy, bus.active_cmd, bus.cmd_enable);
    end
    tick(1'b0, 1'b0, 8'h00, 4'b0001);
    checks++;
    if (bus.busy !== 1'b1 || bus.active_cmd !== 2'd3) begin
      errors++;
      $display("FAIL foreign_done: got busy=%b act=%0d required 1/3",
               bus.busy, bus.active_cmd);
    end
    tick(1'b0, 1'b1, 8'h77, 4'h0);
    checks++;
    if (bus.cmd_enable !== 4'b1000 || bus.cmd_data !== 8'h77) begin
      errors++;
      $display("FAIL done_op_byte: got en=%b data=%h required 1000/77",
               bus.cmd_enable, bus.cmd_data);
    end
    tick(1'b0, 1'b0, 8'h00, 4'b1000);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    tick(1'b0, 1'b1, 8'h4C, 4'h0);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      tick(1'b0, 1'b1, d, 4'h0);
      checks++;
      if (bus.cmd_enable !== 4'b0010 || bus.cmd_data !== d) begin
        errors++;
        $display("FAIL b2b_%0d: got en=%b data=%h required 0010/%h",
                 i, bus.cmd_enable, bus.cmd_data, d);
      end
    end
    tick(1'b1, 1'b1, 8'h5A, 4'h0);
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_enable !== 4'h0 ||
        bus.cmd_data !== 8'h00 || bus.active_cmd !== 2'd0 ||
        bus.err_unknown !== 1'b0 || bus.err_timeout !== 1'b0 ||
        bus.cmd_reset !== 4'h0) begin
      errors++;
      $display("FAIL midreset: got busy=%b en=%b data=%h act=%0d eu=%b et=%b",
               bus.busy, bus.cmd_enable, bus.cmd_data, bus.active_cmd,
               bus.err_unknown, bus.err_timeout);
    end
    tick(1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  task automatic test_random();
    bit         v;
    logic [7:0] d;
    logic [3:0] done;
    int         r;
    int         rate;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rate = ($urandom % 2 == 0) ? 2 : 24;
      v = ($urandom % rate == 0);
      r = int'($urandom % 10);
      if (r < 4) d = op_tab[r];
      else if (r == 4) d = 8'h00;
      else d = 8'($urandom);
      done = '0;
      if ($urandom % 10 == 0) done[$urandom % 4] = 1'b1;
      if (m_route && $urandom % 12 == 0) done[m_h] = 1'b1;
      tick(1'b0, v, d, done);
      checks++;
      if (bus.cmd_enable !== e_enable) begin
        errors++;
        $display("FAIL rnd_enable c%0d: got %b required %b",
                 c, bus.cmd_enable, e_enable);
      end
      if (e_enable != 4'h0) begin
        checks++;
        if (bus.cmd_data !== e_data) begin
          errors++;
          $display("FAIL rnd_data c%0d: got %h required %h",
                   c, bus.cmd_data, e_data);
        end
      end
      checks++;
      if (bus.busy !== (m_route || m_abort)) begin
        errors++;
        $display("FAIL rnd_busy c%0d: got %b required %b",
                 c, bus.busy, (m_route || m_abort));
      end
      if (m_route || m_abort) begin
        checks++;
        if (bus.active_cmd !== 2'(m_h)) begin
          errors++;
          $display("FAIL rnd_active c%0d: got %0d required %0d",
                   c, bus.active_cmd, m_h);
        end
      end
      checks++;
      if (bus.err_unknown !== e_eunk || bus.err_timeout !== e_etmo ||
          bus.cmd_reset !== e_creset) begin
        errors++;
        $display("FAIL rnd_err c%0d: got eu=%b et=%b crst=%b required %b/%b/%b",
                 c, bus.err_unknown, bus.err_timeout, bus.cmd_reset,
                 e_eunk, e_etmo, e_creset);
      end
    end
  endtask

  initial begin
    op_tab[0] = 8'h52; op_tab[1] = 8'h4C;
    op_tab[2] = 8'h46; op_tab[3] = 8'h42;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.cmd_done = 4'h0;
    m_route      = 1'b0;
    m_abort      = 1'b0;
    m_h          = 0;
    m_silent     = 0;
    e_data       = '0;
    test_reset();
    test_route_basic();
    test_unknown_nop();
    test_timeout();
    test_done_opcode();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
